// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the packet fifo write port.
// Define FIFO_ARB_PRIO_EN for fixed lowest-index-wins priority instead.
module fifo_wr_arbiter #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int AW    = 2,
   parameter int DEPTH = 16,
   localparam int LW   = $clog2(DEPTH + 1),
   localparam int PW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_src,
   input  logic [NREQ*AW-1:0] req_dst,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    gnt,
   input  logic               readp,
   input  logic               fullp,
   output logic               writep,
   output logic [AW-1:0]      src_in,
   output logic [AW-1:0]      dst_in,
   output logic [DW-1:0]      data_in,
   output logic [LW-1:0]      level
);

   logic          writep_q, writep_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [DW-1:0] data_q, data_d;
   logic [LW-1:0] level_q, level_d;
   logic [PW-1:0] gidx;
   logic          gvld;
   logic          ok;
   logic          xfer;
   logic          rd;

`ifndef FIFO_ARB_PRIO_EN
   logic [PW-1:0] ptr_q, ptr_d;
`endif

   assign ok = (level_q < LW'(DEPTH)) && !fullp;

`ifdef FIFO_ARB_PRIO_EN
   // Fixed priority: lowest-index pending request wins
   always_comb begin
      gvld = 1'b0;
      gidx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gvld && req[PW'(k)]) begin
            gvld = 1'b1;
            gidx = PW'(k);
         end
      end
   end
`else
   // Round-robin: first pending request at or above ptr, with wrap
   always_comb begin
      int j;
      j    = 0;
      gvld = 1'b0;
      gidx = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!gvld && req[PW'(j)]) begin
            gvld = 1'b1;
            gidx = PW'(j);
         end
      end
   end
`endif

   // Grant is forced low while reset is held so outputs read zero at once
   assign gnt  = (rstn && ok && gvld) ? (NREQ'(1) << gidx) : '0;
   assign xfer = |(req & gnt);
   assign rd   = readp && (level_q != '0);

   // Next-state: capture granted fields, track committed occupancy
   always_comb begin
      writep_d = xfer;
      src_d    = src_q;
      dst_d    = dst_q;
      data_d   = data_q;
      level_d  = level_q;
      if (xfer) begin
         src_d  = req_src[int'(gidx)*AW +: AW];
         dst_d  = req_dst[int'(gidx)*AW +: AW];
         data_d = req_data[int'(gidx)*DW +: DW];
      end
      if (xfer && !rd) level_d = level_q + LW'(1);
      else if (!xfer && rd) level_d = level_q - LW'(1);
   end

`ifndef FIFO_ARB_PRIO_EN
   // Pointer moves just past the winner so it gets lowest priority next
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
   end

   // Round-robin pointer register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`endif

   // Write-port and occupancy registers; reset drops any pending write
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         writep_q <= 1'b0;
         src_q    <= '0;
         dst_q    <= '0;
         data_q   <= '0;
         level_q  <= '0;
      end else begin
         writep_q <= writep_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         data_q   <= data_d;
         level_q  <= level_d;
      end
   end

   assign writep  = writep_q;
   assign src_in  = src_q;
   assign dst_in  = dst_q;
   assign data_in = data_q;
   assign level   = level_q;

endmodule
